// File: rtl/cmd_sched_pkg.sv
// Shared opcodes, FSM encoding, status-word layout and register addresses for command_scheduler.
package cmd_sched_pkg;

    localparam logic [3:0] OP_NOP          = 4'h0;
    localparam logic [3:0] OP_REG_WRITE    = 4'h1;
    localparam logic [3:0] OP_REG_READ     = 4'h2;
    localparam logic [3:0] OP_RENDER_MIN   = 4'h3;
    localparam logic [3:0] OP_RENDER_MAX   = 4'hE;
    localparam logic [3:0] OP_CLEAR_STATUS = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int unsigned STATUS_BUSY_BIT  = 15;
    localparam int unsigned STATUS_OVF_BIT   = 14;
    localparam int unsigned STATUS_STATE_LSB = 12;

    localparam logic [3:0] REG_STATUS  = 4'hF;
    localparam logic [3:0] REG_DROPCNT = 4'hE;

    typedef struct packed {
        logic [15:0] cmd;
        logic [15:0] data;
    } render_cmd_t;

    function automatic logic is_render(input logic [3:0] op);
        return (op >= OP_RENDER_MIN) && (op <= OP_RENDER_MAX);
    endfunction

endpackage

// File: rtl/cmd_sched_fifo.sv
// Synchronous render-command FIFO; a push while full is accepted only when a pop happens the same cycle.
module cmd_sched_fifo
    import cmd_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  render_cmd_t       wdata,
    input  logic              pop,
    output render_cmd_t       rdata_c,
    output logic              empty_c,
    output logic              push_ok_c,
    output logic [FIFO_AW:0]  count
);

    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

    render_cmd_t          mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic                 full_c;
    logic                 pop_ok;

    assign empty_c   = (count == '0);
    assign full_c    = (count == DEPTH_CNT);
    assign pop_ok    = pop && !empty_c;
    assign push_ok_c = push && (!full_c || pop_ok);
    assign rdata_c   = mem[rd_ptr];

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop_ok)    rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_ok_c, pop_ok})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/command_scheduler.sv
// Host command decoder: config shadow file, readback, and a render FIFO issued one at a time to the engine.
// Optional macro CMD_SCHED_DROP_COUNT_EN adds a saturating dropped-render counter readable at 0xE.
module command_scheduler
    import cmd_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic        commandClk,
    input  logic        resetN,
    input  logic [15:0] commandIn,
    input  logic [15:0] dataIn,
    output logic [15:0] readData,
    output logic        cfgWe,
    output logic [3:0]  cfgAddr,
    output logic [15:0] cfgData,
    output logic [15:0] engCmd,
    output logic [15:0] engData,
    output logic        engValid,
    input  logic        engReady,
    input  logic        engDone,
    output logic        busy,
    output logic        overflow
);

    logic [3:0]        opcode;
    logic [3:0]        reg_addr;
    logic              wr_c, rd_c, clr_c, push_c, pop_c, drop_c;
    logic              push_ok_c, fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    render_cmd_t       fifo_head, push_word;
    logic [1:0]        state_q, state_d;
    logic              eng_valid_d;
    logic [15:0]       eng_cmd_d, eng_data_d;
    logic [15:0]       shadow [16];
    logic [15:0]       status_c, rd_word_c;

    assign opcode    = commandIn[15:12];
    assign reg_addr  = commandIn[3:0];
    assign push_word = '{cmd: commandIn, data: dataIn};

    // Opcode decode; the status address is not writable.
    always_comb begin
        wr_c   = 1'b0;
        rd_c   = 1'b0;
        clr_c  = 1'b0;
        push_c = 1'b0;
        case (opcode)
            OP_NOP:          ;
            OP_REG_WRITE:    wr_c  = (reg_addr != REG_STATUS);
            OP_REG_READ:     rd_c  = 1'b1;
            OP_CLEAR_STATUS: clr_c = 1'b1;
            default:         push_c = is_render(opcode);
        endcase
    end

    assign drop_c = push_c && !push_ok_c;
    assign busy   = (state_q != ST_IDLE) || !fifo_empty;

    cmd_sched_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk       (commandClk),
        .rst_n     (resetN),
        .push      (push_c),
        .wdata     (push_word),
        .pop       (pop_c),
        .rdata_c   (fifo_head),
        .empty_c   (fifo_empty),
        .push_ok_c (push_ok_c),
        .count     (fifo_count)
    );

    always_comb begin
        status_c = '0;
        status_c[STATUS_BUSY_BIT]        = busy;
        status_c[STATUS_OVF_BIT]         = overflow;
        status_c[STATUS_STATE_LSB +: 2]  = state_q;
        status_c[FIFO_AW:0]              = fifo_count;
    end

`ifdef CMD_SCHED_DROP_COUNT_EN
    logic [7:0] drop_count;

    always_ff @(posedge commandClk or negedge resetN) begin
        if (!resetN)                              drop_count <= '0;
        else if (drop_c && drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
        else if (clr_c)                           drop_count <= '0;
    end
`endif

    always_comb begin
        rd_word_c = shadow[reg_addr];
        if (reg_addr == REG_STATUS) rd_word_c = status_c;
`ifdef CMD_SCHED_DROP_COUNT_EN
        else if (reg_addr == REG_DROPCNT) rd_word_c = {8'd0, drop_count};
`endif
    end

    always_ff @(posedge commandClk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 16; i++) shadow[i] <= '0;
        end else if (wr_c) begin
            shadow[reg_addr] <= dataIn;
        end
    end

    // Host-side registered outputs; a dropped push wins over a clear.
    always_ff @(posedge commandClk or negedge resetN) begin
        if (!resetN) begin
            readData <= '0;
            cfgWe    <= 1'b0;
            cfgAddr  <= '0;
            cfgData  <= '0;
            overflow <= 1'b0;
        end else begin
            cfgWe <= wr_c;
            if (wr_c) begin
                cfgAddr <= reg_addr;
                cfgData <= dataIn;
            end
            if (rd_c)        readData <= rd_word_c;
            if (drop_c)      overflow <= 1'b1;
            else if (clr_c)  overflow <= 1'b0;
        end
    end

    // Issue FSM: one render command in flight at a time.
    always_comb begin
        state_d     = state_q;
        eng_valid_d = engValid;
        eng_cmd_d   = engCmd;
        eng_data_d  = engData;
        pop_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c       = 1'b1;
                    eng_valid_d = 1'b1;
                    eng_cmd_d   = fifo_head.cmd;
                    eng_data_d  = fifo_head.data;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (engValid && engReady) begin
                    eng_valid_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (engDone) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge commandClk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            engValid <= 1'b0;
            engCmd   <= '0;
            engData  <= '0;
        end else begin
            state_q  <= state_d;
            engValid <= eng_valid_d;
            engCmd   <= eng_cmd_d;
            engData  <= eng_data_d;
        end
    end

endmodule

// File: tb/tb_command_scheduler.sv
// Self-checking bench for command_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_command_scheduler;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic        commandClk = 1'b0;
    logic        resetN;
    logic [15:0] commandIn, dataIn;
    logic [15:0] readData, cfgData, engCmd, engData;
    logic [3:0]  cfgAddr;
    logic        cfgWe, engValid, engReady, engDone, busy, overflow;

    always #5 commandClk = ~commandClk;

    command_scheduler #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
        .commandClk (commandClk),
        .resetN     (resetN),
        .commandIn  (commandIn),
        .dataIn     (dataIn),
        .readData   (readData),
        .cfgWe      (cfgWe),
        .cfgAddr    (cfgAddr),
        .cfgData    (cfgData),
        .engCmd     (engCmd),
        .engData    (engData),
        .engValid   (engValid),
        .engReady   (engReady),
        .engDone    (engDone),
        .busy       (busy),
        .overflow   (overflow)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: render commands live in a queue, engine side is a 3-phase state number.
    logic [31:0] m_q[$];
    logic [15:0] m_shadow [16];
    int          m_st;
    logic        m_valid, m_we, m_ovf;
    logic [15:0] m_ecmd, m_edata, m_rd, m_cdata;
    logic [3:0]  m_caddr;
    int          m_dc;

    function automatic logic m_busy();
        return (m_st != 0) || (m_q.size() != 0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 16; i++) m_shadow[i] = '0;
        m_st = 0; m_valid = 0; m_we = 0; m_ovf = 0;
        m_ecmd = '0; m_edata = '0; m_rd = '0; m_cdata = '0; m_caddr = '0; m_dc = 0;
    endtask

    task automatic model_step(input logic [15:0] c, input logic [15:0] d, input logic r, input logic dn);
        logic [3:0]  op, a;
        logic [15:0] st;
        logic [31:0] head;
        bit          pop;
        op  = c[15:12];
        a   = c[3:0];
        st  = {m_busy(), m_ovf, 2'(m_st), 12'(m_q.size())};
        pop = (m_st == 0) && (m_q.size() > 0);
        m_we = 0;
        if (op == 4'h1 && a != 4'hF) begin
            m_shadow[a] = d; m_we = 1; m_caddr = a; m_cdata = d;
        end
        if (op == 4'h2) begin
            if (a == 4'hF) m_rd = st;
`ifdef CMD_SCHED_DROP_COUNT_EN
            else if (a == 4'hE) m_rd = 16'(m_dc);
`endif
            else m_rd = m_shadow[a];
        end
        case (m_st)
            0: if (pop) begin
                head = m_q.pop_front();
                m_ecmd = head[31:16]; m_edata = head[15:0]; m_valid = 1; m_st = 1;
            end
            1: if (r) begin m_valid = 0; m_st = 2; end
            2: if (dn) m_st = 0;
            default: ;
        endcase
        if (op == 4'hF) begin m_ovf = 0; m_dc = 0; end
        if (op >= 4'h3 && op <= 4'hE) begin
            if (m_q.size() < DEPTH) m_q.push_back({c, d});
            else begin m_ovf = 1; if (m_dc < 255) m_dc++; end
        end
    endtask

    task automatic check_all();
        check("readData", readData, m_rd);
        check("cfgWe",    cfgWe,    m_we);
        check("cfgAddr",  cfgAddr,  m_caddr);
        check("cfgData",  cfgData,  m_cdata);
        check("engValid", engValid, m_valid);
        check("engCmd",   engCmd,   m_ecmd);
        check("engData",  engData,  m_edata);
        check("busy",     busy,     m_busy());
        check("overflow", overflow, m_ovf);
    endtask

    task automatic apply(input logic [15:0] c, input logic [15:0] d, input logic r, input logic dn);
        commandIn = c; dataIn = d; engReady = r; engDone = dn;
        model_step(c, d, r, dn);
        @(posedge commandClk); #1;
        check_all();
    endtask

    task automatic check_reset_zero();
        check("rst_readData", readData, 0);
        check("rst_cfgWe",    cfgWe,    0);
        check("rst_cfgAddr",  cfgAddr,  0);
        check("rst_cfgData",  cfgData,  0);
        check("rst_engValid", engValid, 0);
        check("rst_engCmd",   engCmd,   0);
        check("rst_engData",  engData,  0);
        check("rst_busy",     busy,     0);
        check("rst_overflow", overflow, 0);
    endtask

    task automatic do_reset();
        commandIn = '0; dataIn = '0; engReady = 0; engDone = 0;
        resetN = 0;
        #2;
        check_reset_zero();
        model_reset();
        @(posedge commandClk); #1;
        resetN = 1;
    endtask

    initial begin
        logic [15:0] c, d;
        int pick;
        commandIn = '0; dataIn = '0; engReady = 0; engDone = 0; resetN = 0;
        model_reset();
        repeat (2) @(posedge commandClk);
        #1;
        check_reset_zero();
        resetN = 1;

        // Config write then readback
        apply(16'h1003, 16'hBEEF, 0, 0);
        check("wr_strobe", cfgWe, 1);
        check("wr_addr",   cfgAddr, 3);
        check("wr_data",   cfgData, 16'hBEEF);
        apply(16'h2003, 16'h0000, 0, 0);
        check("rd_data",   readData, 16'hBEEF);
        check("wr_strobe_off", cfgWe, 0);

        // Single render command through the handshake
        apply(16'h3001, 16'h0011, 1, 0);
        check("push_not_issued", engValid, 0);
        apply(16'h0000, 16'h0000, 1, 0);
        check("issue_valid", engValid, 1);
        check("issue_cmd",   engCmd, 16'h3001);
        apply(16'h0000, 16'h0000, 1, 0);
        check("wait_valid_low", engValid, 0);
        check("wait_busy", busy, 1);
        apply(16'h0000, 16'h0000, 0, 1);
        check("done_busy_low", busy, 0);

        // Engine stall: outputs and FIFO count stay put
        apply(16'h3002, 16'h0022, 0, 0);
        apply(16'h3003, 16'h0033, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(16'h200F, 16'h0000, 0, 0);
            check("stall_valid", engValid, 1);
            check("stall_cmd",   engCmd, 16'h3002);
            check("stall_data",  engData, 16'h0022);
            check("stall_count", readData & 16'h000F, 1);
        end

        // Fill the FIFO, overflow on the next push, then clear
        for (int i = 0; i < 7; i++) apply(16'h4000 + 16'(i), 16'(i), 0, 0);
        apply(16'h200F, 16'h0000, 0, 0);
        check("full_status", readData, 16'h9008);
        apply(16'h4100, 16'h1234, 0, 0);
        check("drop_ovf", overflow, 1);
        apply(16'h200F, 16'h0000, 0, 0);
        check("ovf_status", readData, 16'hD008);
        apply(16'hF000, 16'h0000, 0, 0);
        check("clear_ovf", overflow, 0);

        // Full FIFO with a pop in the same cycle as a push
        apply(16'h0000, 16'h0000, 1, 0);
        apply(16'h0000, 16'h0000, 0, 1);
        apply(16'h5555, 16'hAAAA, 0, 0);
        check("popush_ovf", overflow, 0);
        apply(16'h200F, 16'h0000, 0, 0);
        check("popush_status", readData, 16'h9008);

`ifdef CMD_SCHED_DROP_COUNT_EN
        for (int i = 0; i < 300; i++) apply(16'h6000 + 16'(i), 16'(i), 0, 0);
        apply(16'h200E, 16'h0000, 0, 0);
        check("dropcnt_sat", readData, 16'h00FF);
        apply(16'hF000, 16'h0000, 0, 0);
        apply(16'h200E, 16'h0000, 0, 0);
        check("dropcnt_clr", readData, 16'h0000);
`endif

        // Reset with a command in flight and a full FIFO
        do_reset();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 9));
            d = 16'($urandom);
            case (pick)
                4:       c = {4'h1, 12'($urandom)};
                5:       c = {4'h2, 8'($urandom), ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom)};
                6:       c = ($urandom_range(0, 3) == 0) ? 16'hF000 : {4'h3, 12'($urandom)};
                7:       c = 16'h0000;
                8:       c = {4'h0, 12'($urandom_range(1, 4095))};
                default: c = {4'($urandom_range(3, 14)), 12'($urandom)};
            endcase
            apply(c, d, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            if (n == 1500) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/command_scheduler.md
Name: command_scheduler

Overview:
- Sits between the host command interface and the GPU engines.
- Consumes one-cycle command/data pairs from the interface (command word nonzero = valid) and decodes a 4-bit opcode.
- Maintains a 16-entry config shadow register file and forwards config writes.
- Returns readback words to the interface, and queues render commands in a FIFO that it issues one at a time to the render engine under a valid/ready/done handshake.

Parameters:
FIFO_DEPTH, 8, render command FIFO entries; power of 2, 2..256
FIFO_AW, 3, log2(FIFO_DEPTH); pointer width

Ports:
commandClk  in  1  single clock
resetN  in  1  asynchronous, active-low reset
commandIn  in  16  command from interface; nonzero = valid for this cycle; [15:12] opcode, [11:0] arg
dataIn  in  16  data word paired with commandIn
readData  out  16  readback word to interface (drives its dataFromGpu)
cfgWe  out  1  one-cycle config write strobe
cfgAddr  out  4  config register address
cfgData  out  16  config write data
engCmd  out  16  command word to render engine
engData  out  16  data word to render engine
engValid  out  1  engCmd/engData valid
engReady  in  1  engine accepts when engValid && engReady
engDone  in  1  one-cycle pulse: engine finished current command
busy  out  1  FIFO non-empty or FSM not IDLE
overflow  out  1  sticky: a render command was dropped

Behaviour:
Reset values:
- Reset is asynchronous on resetN low.
- All outputs clear to 0.
- shadow regs = 0, FIFO empty (count 0, pointers 0), FSM = IDLE.

Decode (registered; 1-cycle latency from the commandIn edge):
- 0x0 NOP: no effect.
- 0x1 REG_WRITE:
  - shadow[arg[3:0]] <= dataIn.
  - Next cycle: cfgWe=1, cfgAddr=arg[3:0], cfgData=dataIn.
  - Otherwise cfgWe=0; cfgAddr/cfgData hold their last values.
  - A write to address 0xF is ignored, with no strobe.
- 0x2 REG_READ:
  - readData <= shadow[arg[3:0]], except address 0xF returns the status word.
  - readData holds until the next REG_READ.
- 0x3..0xE: render command; push {commandIn, dataIn} into the FIFO.
- 0xF CLEAR_STATUS: overflow <= 0.
  - If a push is dropped in the same cycle, overflow stays 1 (set wins).

Status word:
- [15] busy, [14] overflow, [13:12] FSM state (IDLE=0, ISSUE=1, WAIT=2).
- [11:FIFO_AW+1] = 0.
- [FIFO_AW:0] FIFO count; holds FIFO_DEPTH when full.

FIFO:
- Push when full is dropped and sets overflow, unless a pop occurs the same cycle, in which case the push is accepted.
- Pointers wrap modulo FIFO_DEPTH.
- Count is FIFO_AW+1 bits and never exceeds FIFO_DEPTH.

FSM:
- IDLE: if FIFO non-empty, pop the head into engCmd/engData, set engValid=1, go to ISSUE.
  - A push into an empty FIFO is issued no earlier than the following cycle.
- ISSUE: hold engValid, engCmd and engData stable.
  - On engValid && engReady: engValid <= 0 next edge, go to WAIT.
  - engDone is ignored in ISSUE.
- WAIT: on engDone go to IDLE; the next pop can happen one cycle after that.
- Exactly one render command is in flight.

Other rules:
- busy is combinational from state and count.
- Reset mid-transaction abandons the in-flight command and the FIFO contents; the engine must be reset alongside.

Optional Feature:
Macro CMD_SCHED_DROP_COUNT_EN.
- Defined:
  - Adds an 8-bit saturating counter of dropped render commands.
  - REG_READ of address 0xE returns {8'd0, dropCount} instead of shadow[14].
  - CLEAR_STATUS zeroes dropCount.
  - The counter resets to 0.
- Undefined: no counter; address 0xE behaves as a normal shadow register.

Decomposition:
- Shared package cmd_sched_pkg holds:
  - opcode constants: OP_NOP, OP_REG_WRITE, OP_REG_READ, OP_CLEAR_STATUS, OP_RENDER_MIN/MAX;
  - the FSM state encoding;
  - status bit positions;
  - the REG_STATUS=0xF and REG_DROPCNT=0xE addresses.
- One sub-module: cmd_sched_fifo.
  - Synchronous FIFO, 32-bit wide, FIFO_DEPTH deep.
  - push/pop/full/empty/count; same-cycle push+pop rule as above.

Test Plan:
- Reset, then REG_WRITE cmd 0x1003 data 0xBEEF, then REG_READ 0x2003 -> cfgWe=1 one cycle with cfgAddr=3, cfgData=0xBEEF; readData=0xBEEF the cycle after the read.
- Push render 0x3001/0x0011 with engReady=1 -> engValid=1 with engCmd=0x3001 two cycles after input; WAIT until engDone pulse; busy falls to 0 the cycle after engDone.
- engReady held 0 for 5 cycles -> engValid, engCmd and engData stay stable; no pop; FIFO count unchanged.
- With engReady=0, push 9 render commands (FIFO_DEPTH=8) -> 8th fills the FIFO (count 8, status[3:0]=8); the 9th is dropped, and status read 0x200F -> bit14=1; then CLEAR_STATUS 0xF000 -> overflow=0.
- Full FIFO, with a push arriving in the same cycle IDLE pops -> push accepted, count stays 8, overflow stays 0.
- With CMD_SCHED_DROP_COUNT_EN: 300 dropped pushes -> read 0x200E returns 0x00FF; CLEAR_STATUS -> 0x0000.
